// File: rtl/operand_bank.sv
// Operand capture bank: NCH channels of WIDTH-bit operands. Once every channel is
// loaded the set freezes until it is consumed. Reports rejected loads and a fill count.

module operand_bank_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (ld) data_d = din;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) data_q <= '0;
    else     data_q <= data_d;

  assign dout = data_q;
endmodule

module operand_bank #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             ld_en,
  input  logic [NCH*WIDTH-1:0]       ld_data,
  input  logic                       consume,
  input  logic                       clr,
  output logic [NCH*WIDTH-1:0]       data_out,
  output logic [NCH-1:0]             valid,
  output logic [$clog2(NCH+1)-1:0]   fill,
  output logic                       ready,
  output logic                       drop
);
  localparam int CW = $clog2(NCH+1);

  typedef enum logic {COLLECT = 1'b0, READY = 1'b1} state_t;

  state_t          state_d, state_q;
  logic [NCH-1:0]  valid_d, valid_q;
  logic [NCH-1:0]  accept;
  logic [CW-1:0]   fill_d, fill_q;
  logic            ready_d, ready_q;
  logic            drop_d, drop_q;

  always_comb begin
    accept  = '0;
    valid_d = valid_q;
    drop_d  = 1'b0;
    if (clr) begin
      // Flags flush; captured data is left in place.
      valid_d = '0;
      drop_d  = |ld_en;
    end else if (state_q == READY) begin
      if (consume) begin
        // Same-cycle loads seed the next set instead of being dropped.
        accept  = ld_en;
        valid_d = ld_en;
      end else begin
        drop_d  = |ld_en;
      end
    end else begin
      accept  = ld_en;
      valid_d = valid_q | ld_en;
    end
    state_d = (!clr && (&valid_d)) ? READY : COLLECT;
    ready_d = (state_d == READY);
    fill_d  = '0;
    for (int i = 0; i < NCH; i++) fill_d = fill_d + CW'(valid_d[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      valid_q <= '0;
      fill_q  <= '0;
      ready_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    operand_bank_lane #(.WIDTH(WIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .ld   (accept[g]),
      .din  (ld_data[g*WIDTH +: WIDTH]),
      .dout (data_out[g*WIDTH +: WIDTH])
    );
  end

  assign valid = valid_q;
  assign fill  = fill_q;
  assign ready = ready_q;
  assign drop  = drop_q;
endmodule

// File: tb/tb_operand_bank.sv
// Bench for operand_bank: a cycle model checks the 8x2 instance every cycle,
// directed literal checks pin the model, and a 16x5 instance covers packing.

module tb_operand_bank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Instance A: WIDTH=8, NCH=2
  logic [1:0]  a_ld_en = '0;
  logic [15:0] a_ld_data = '0;
  logic        a_consume = 1'b0, a_clr = 1'b0;
  logic [15:0] a_data_out;
  logic [1:0]  a_valid;
  logic [1:0]  a_fill;
  logic        a_ready, a_drop;

  operand_bank #(.WIDTH(8), .NCH(2)) dut_a (
    .clk(clk), .rst(rst), .ld_en(a_ld_en), .ld_data(a_ld_data),
    .consume(a_consume), .clr(a_clr), .data_out(a_data_out),
    .valid(a_valid), .fill(a_fill), .ready(a_ready), .drop(a_drop)
  );

  // Instance B: WIDTH=16, NCH=5
  logic [4:0]  b_ld_en = '0;
  logic [79:0] b_ld_data = '0;
  logic        b_consume = 1'b0, b_clr = 1'b0;
  logic [79:0] b_data_out;
  logic [4:0]  b_valid;
  logic [2:0]  b_fill;
  logic        b_ready, b_drop;

  operand_bank #(.WIDTH(16), .NCH(5)) dut_b (
    .clk(clk), .rst(rst), .ld_en(b_ld_en), .ld_data(b_ld_data),
    .consume(b_consume), .clr(b_clr), .data_out(b_data_out),
    .valid(b_valid), .fill(b_fill), .ready(b_ready), .drop(b_drop)
  );

  // Behavioural model of instance A: a set of operands plus "frozen" flag.
  logic [7:0] m_data [2];
  bit         m_valid [2];
  bit         m_frozen;
  bit         m_drop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin m_data[i] = 8'h00; m_valid[i] = 0; end
      m_frozen = 0;
      m_drop   = 0;
    end else begin
      m_drop = 0;
      if (a_clr) begin
        for (int i = 0; i < 2; i++) m_valid[i] = 0;
        m_drop   = (a_ld_en != 0);
        m_frozen = 0;
      end else if (m_frozen && !a_consume) begin
        m_drop = (a_ld_en != 0);
      end else begin
        int cnt;
        if (m_frozen) for (int i = 0; i < 2; i++) m_valid[i] = 0;
        for (int i = 0; i < 2; i++)
          if (a_ld_en[i]) begin
            m_data[i]  = a_ld_data[i*8 +: 8];
            m_valid[i] = 1;
          end
        cnt = 0;
        for (int i = 0; i < 2; i++) cnt += int'(m_valid[i]);
        m_frozen = (cnt == 2);
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 2; i++) begin
        cnt += int'(m_valid[i]);
        n_cmp++;
        if (a_data_out[i*8 +: 8] !== m_data[i]) begin
          n_err++;
          $display("FAIL model_data ch%0d got %h want %h @%0t", i, a_data_out[i*8 +: 8], m_data[i], $time);
        end
        n_cmp++;
        if (a_valid[i] !== m_valid[i]) begin
          n_err++;
          $display("FAIL model_valid ch%0d got %b want %b @%0t", i, a_valid[i], m_valid[i], $time);
        end
      end
      n_cmp++;
      if (int'(a_fill) != cnt || $isunknown(a_fill)) begin
        n_err++;
        $display("FAIL model_fill got %0d want %0d @%0t", a_fill, cnt, $time);
      end
      n_cmp++;
      if (a_ready !== m_frozen) begin
        n_err++;
        $display("FAIL model_ready got %b want %b @%0t", a_ready, m_frozen, $time);
      end
      n_cmp++;
      if (a_drop !== m_drop) begin
        n_err++;
        $display("FAIL model_drop got %b want %b @%0t", a_drop, m_drop, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic [1:0] en, input logic [15:0] d, input logic cons, input logic c);
    a_ld_en = en; a_ld_data = d; a_consume = cons; a_clr = c;
  endtask

  localparam int ORDER [5] = '{4, 0, 2, 1, 3};

  initial begin
    rst = 1'b1;
    #12;
    chk("rst_data", 80'(a_data_out), 80'h0);
    chk("rst_valid", 80'(a_valid), 80'h0);
    chk("rst_fill", 80'(a_fill), 80'h0);
    chk("rst_ready", 80'(a_ready), 80'h0);
    chk("rst_drop", 80'(a_drop), 80'h0);
    rst = 1'b0;
    step();
    cmp_en = 1'b1;

    // Sequential fill
    a_drive(2'b01, 16'h003C, 0, 0); step();
    chk("seq_fill1", 80'(a_fill), 80'd1);
    a_drive(2'b10, 16'hA500, 0, 0); step();
    chk("seq_fill2", 80'(a_fill), 80'd2);
    chk("seq_ready", 80'(a_ready), 80'd1);
    chk("seq_data", 80'(a_data_out), 80'hA53C);
    a_drive(2'b00, 16'h0000, 1, 0); step();
    chk("cons_ready", 80'(a_ready), 80'd0);
    chk("cons_valid", 80'(a_valid), 80'd0);

    // Overwrite then simultaneous load
    a_drive(2'b01, 16'h0011, 0, 0); step();
    a_drive(2'b01, 16'h0022, 0, 0); step();
    chk("ovw_valid", 80'(a_valid), 80'b01);
    chk("ovw_data", 80'(a_data_out[7:0]), 80'h22);
    chk("ovw_drop", 80'(a_drop), 80'd0);
    a_drive(2'b11, 16'h4433, 0, 0); step();
    chk("sim_ready", 80'(a_ready), 80'd1);
    chk("sim_data", 80'(a_data_out), 80'h4433);

    // Blocked load
    a_drive(2'b10, 16'hFF00, 0, 0); step();
    chk("blk_data", 80'(a_data_out), 80'h4433);
    chk("blk_drop", 80'(a_drop), 80'd1);
    chk("blk_ready", 80'(a_ready), 80'd1);
    a_drive(2'b00, 16'h0000, 0, 0); step();
    chk("blk_drop_pulse", 80'(a_drop), 80'd0);

    // Consume with same-cycle load
    a_drive(2'b01, 16'h005A, 1, 0); step();
    chk("cl_ready", 80'(a_ready), 80'd0);
    chk("cl_valid", 80'(a_valid), 80'b01);
    chk("cl_data", 80'(a_data_out[7:0]), 80'h5A);
    chk("cl_fill", 80'(a_fill), 80'd1);
    chk("cl_drop", 80'(a_drop), 80'd0);
    a_drive(2'b10, 16'h9900, 0, 0); step();
    chk("cl_refill", 80'(a_data_out), 80'h995A);
    a_drive(2'b11, 16'hBBCC, 1, 0); step();
    chk("cf_ready", 80'(a_ready), 80'd1);
    chk("cf_data", 80'(a_data_out), 80'hBBCC);
    a_drive(2'b11, 16'h1357, 1, 0); step();
    chk("tput_data1", 80'(a_data_out), 80'h1357);
    a_drive(2'b11, 16'h2468, 1, 0); step();
    chk("tput_data2", 80'(a_data_out), 80'h2468);
    chk("tput_ready", 80'(a_ready), 80'd1);

    // clr with same-cycle load
    a_drive(2'b01, 16'h0012, 1, 0); step();
    chk("pre_clr_valid", 80'(a_valid), 80'b01);
    a_drive(2'b00, 16'h0000, 1, 0); step();
    chk("collect_consume_ignored", 80'(a_valid), 80'b01);
    a_drive(2'b10, 16'h3400, 0, 1); step();
    chk("clr_valid", 80'(a_valid), 80'b00);
    chk("clr_drop", 80'(a_drop), 80'd1);
    chk("clr_keep", 80'(a_data_out[7:0]), 80'h12);
    chk("clr_ready", 80'(a_ready), 80'd0);

    // Async reset between edges
    a_drive(2'b01, 16'h0056, 0, 0); step();
    chk("pre_rst_valid", 80'(a_valid), 80'b01);
    a_drive(2'b00, 16'h0000, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_data", 80'(a_data_out), 80'h0);
    chk("arst_valid", 80'(a_valid), 80'h0);
    chk("arst_fill", 80'(a_fill), 80'h0);
    chk("arst_ready", 80'(a_ready), 80'h0);
    rst = 1'b0;
    step();
    step();

    // Instance B: fill in order 4,0,2,1,3
    for (int k = 0; k < 5; k++) begin
      b_ld_en = 5'b00001 << ORDER[k];
      b_ld_data = '0;
      b_ld_data[ORDER[k]*16 +: 16] = 16'hC000 + 16'(ORDER[k] * 16'h0111);
      step();
      chk($sformatf("b_fill%0d", k + 1), 80'(b_fill), 80'(k + 1));
      chk($sformatf("b_ready%0d", k + 1), 80'(b_ready), 80'(k == 4));
    end
    b_ld_en = '0;
    step();
    for (int c = 0; c < 5; c++)
      chk($sformatf("b_data_ch%0d", c), 80'(b_data_out[c*16 +: 16]), 80'(16'hC000 + 16'(c * 16'h0111)));
    chk("b_data_all", b_data_out, 80'hC444_C333_C222_C111_C000);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/operand_bank.md
# operand_bank

Parametrised operand capture bank for the datapath front end. It latches up to NCH independent WIDTH-bit operands, each under its own load enable, and tracks which channels hold fresh data. Once every channel is loaded it raises a registered ready flag and freezes the captured operand set. The set stays frozen until the downstream consumer acknowledges it with a consume pulse. It replaces the fixed two-operand, 8-bit capture register, adding simultaneous loads, a consume/clear handshake, drop reporting and a fill count.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- NCH, 2, number of operand channels (≥1)
- CW, $clog2(NCH+1), width of fill count (derived, not overridable)
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, asynchronous, active-high
- ld_en  in  NCH  per-channel load enable; bit i loads channel i
- ld_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- consume  in  1  consumer acknowledges the frozen set; only meaningful while ready=1
- clr  in  1  synchronous flush of all valid flags, any state
- data_out  out  NCH*WIDTH  captured operands, same packing as ld_data
- valid  out  NCH  per-channel "holds fresh operand" flags
- fill  out  CW  popcount of valid
- ready  out  1  all channels valid, set frozen
- drop  out  1  one-cycle pulse: a load was rejected this cycle

## Operation
- Two states: COLLECT and READY. Reset state is COLLECT.
- COLLECT:
  - Each channel with ld_en[i]=1 captures ld_data[i] and sets valid[i].
  - Any number of channels may load in the same cycle.
  - Reloading an already-valid channel overwrites its data; valid stays 1; no drop.
  - When the next-state valid vector is all ones, go to READY.
- READY:
  - data_out and valid are frozen.
  - Any ld_en bit set with consume=0 is ignored, and drop pulses the next cycle.
- Consume in READY (consume=1):
  - All valid flags clear.
  - Channels with ld_en[i]=1 in that same cycle are accepted as the first members of the new set: data captured, valid[i]=1. They are not dropped.
  - Go to COLLECT. If every ld_en bit was set, go straight back to READY.
- consume while in COLLECT is ignored (no effect, no error).
- clr has top priority below rst:
  - Clears all valid bits and returns to COLLECT.
  - Same-cycle loads are discarded, and drop pulses if any ld_en was set.
  - data_out keeps its previous values; only the flags clear.
- data_out of a non-valid channel holds its last captured value. It is not zeroed.
- fill = number of set valid bits, range 0..NCH.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Reset values: data_out=0, valid=0, fill=0, ready=0, drop=0, state=COLLECT.
- rst asserted mid-set discards all captured data asynchronously.
- Load latency: data_out, valid and fill update on the clk edge at which ld_en is sampled.
- ready rises on the same edge as the last missing valid bit.
- ready falls on the edge that samples consume=1 or clr=1. It re-rises on that same edge only in the all-channels-reloaded consume case.
- drop is high for exactly one cycle per rejecting edge. It is not sticky.
- Throughput: one full set per cycle is sustainable when ld_en is all ones and consume is held high.

## Test plan
- Reset and sequential fill (WIDTH=8, NCH=2):
  - Assert rst → all outputs 0.
  - Load ch0=0x3C, then ch1=0xA5 on the next cycle.
  - Expect fill 1→2; ready=1 after the second edge; data_out=0xA53C.
- Simultaneous load and overwrite:
  - ld_en=2'b01 with 0x11, then 2'b01 with 0x22.
  - Expect valid=01, data ch0=0x22, drop=0.
  - Then ld_en=2'b11 with {0x44,0x33} → ready=1, data_out=0x4433.
- Blocked load:
  - In READY, ld_en=2'b10 with 0xFF, consume=0.
  - Expect data_out unchanged, drop=1 for one cycle, ready stays 1.
- Consume with same-cycle load:
  - In READY, consume=1 with ld_en=2'b01, 0x5A.
  - Expect ready=0, valid=01, ch0=0x5A, fill=1, drop=0.
  - Repeat with ld_en=2'b11 → ready stays 1 with the new data.
- clr and async reset mid-operation:
  - With valid=01, assert clr together with ld_en=2'b10 → valid=00, drop=1, ch0 data retained.
  - Then load ch0 and assert rst between clock edges → all outputs 0 immediately.
- Parameter sweep:
  - Run WIDTH=16, NCH=5.
  - Load channels in order 4,0,2,1,3 → fill goes 1..5; ready on the fifth edge; packing checked per channel.
